// File: rtl/nco_phase_sequencer_if.sv
// rtl/nco_phase_sequencer_if.sv - phase stream between the sequencer and the NCO lookup stage
// master = sequencer (drives phase/valids), slave = NCO side (drives ready back-pressure).
interface nco_phase_sequencer_if;
    logic [2:0] op_phase;
    logic       op_phase_valid;
    logic       op_sample_valid;
    logic       ip_ready;

    modport master (
        output op_phase,
        output op_phase_valid,
        output op_sample_valid,
        input  ip_ready
    );

    modport slave (
        input  op_phase,
        input  op_phase_valid,
        input  op_sample_valid,
        output ip_ready
    );
endinterface

// File: rtl/nco_phase_sequencer.sv
// rtl/nco_phase_sequencer.sv - phase-accumulator burst/continuous sequencer for the sine/cosine NCO
// Optional NCO_PHASE_ROUND_EN: issued phase rounds to nearest instead of truncating.
module nco_phase_sequencer #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 12
) (
    input  logic                  ip_clock,
    input  logic                  ip_reset,
    input  logic                  ip_start,
    input  logic                  ip_stop,
    input  logic [ACC_W-1:0]      ip_ftw,
    input  logic                  ip_ftw_load,
    input  logic [2:0]            ip_phase_offset,
    input  logic [CNT_W-1:0]      ip_burst_len,
    nco_phase_sequencer_if.master nco,
    output logic                  op_busy,
    output logic                  op_done,
    output logic [CNT_W-1:0]      op_sample_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] ftw_act_q, ftw_act_d;
    logic [ACC_W-1:0] ftw_sh_q, ftw_sh_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       phase_q, phase_d;
    logic             pvalid_q, pvalid_d;
    logic             svalid_q, svalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] ftw_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       phase_src;
    logic             burst_end;

    // A load on the same edge as a start or wrap hands the fresh word straight through.
    assign ftw_next  = ip_ftw_load ? ip_ftw : ftw_sh_q;
    assign acc_sum   = {1'b0, acc_q} + {1'b0, ftw_act_q};
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign burst_end = (burst_q != '0) && (cnt_inc == burst_q);

`ifdef NCO_PHASE_ROUND_EN
    // Adding half an LSB of the 3-bit index only carries in when the next bit down is set.
    assign phase_src = acc_q[ACC_W-1:ACC_W-3] + {2'b00, acc_q[ACC_W-4]};
`else
    assign phase_src = acc_q[ACC_W-1:ACC_W-3];
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ftw_act_d = ftw_act_q;
        ftw_sh_d  = ip_ftw_load ? ip_ftw : ftw_sh_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        pvalid_d  = 1'b0;
        svalid_d  = pvalid_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ip_start) begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    burst_d   = ip_burst_len;
                    ftw_act_d = ftw_next;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ip_stop) begin
                    state_d = ST_FLUSH;
                end else if (!nco.ip_ready) begin
                    state_d = ST_HOLD;
                end else begin
                    phase_d  = phase_src + ip_phase_offset;
                    pvalid_d = 1'b1;
                    acc_d    = acc_sum[ACC_W-1:0];
                    cnt_d    = cnt_inc;
                    if (acc_sum[ACC_W]) begin
                        ftw_act_d = ftw_next;
                    end
                    if (burst_end) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_HOLD: begin
                if (ip_stop) begin
                    state_d = ST_FLUSH;
                end else if (nco.ip_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ip_clock or negedge ip_reset) begin
        if (!ip_reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            ftw_act_q <= '0;
            ftw_sh_q  <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            phase_q   <= '0;
            pvalid_q  <= 1'b0;
            svalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ftw_act_q <= ftw_act_d;
            ftw_sh_q  <= ftw_sh_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            pvalid_q  <= pvalid_d;
            svalid_q  <= svalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign nco.op_phase        = phase_q;
    assign nco.op_phase_valid  = pvalid_q;
    assign nco.op_sample_valid = svalid_q;
    assign op_busy             = busy_q;
    assign op_done             = done_q;
    assign op_sample_count     = cnt_q;

endmodule

// File: tb/tb_nco_phase_sequencer.sv
// tb/tb_nco_phase_sequencer.sv - self-checking bench for nco_phase_sequencer
module tb_nco_phase_sequencer;
    localparam int ACC_W = 16;
    localparam int CNT_W = 12;

    logic             ip_clock = 1'b0;
    logic             ip_reset = 1'b0;
    logic             ip_start = 1'b0;
    logic             ip_stop = 1'b0;
    logic             ip_ftw_load = 1'b0;
    logic [ACC_W-1:0] ip_ftw = '0;
    logic [2:0]       ip_phase_offset = '0;
    logic [CNT_W-1:0] ip_burst_len = '0;
    logic             op_busy;
    logic             op_done;
    logic [CNT_W-1:0] op_sample_count;

    int checks = 0;
    int failures = 0;
    int obs[$];
    int exp_q[$];

    nco_phase_sequencer_if nif ();

    nco_phase_sequencer #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .ip_clock        (ip_clock),
        .ip_reset        (ip_reset),
        .ip_start        (ip_start),
        .ip_stop         (ip_stop),
        .ip_ftw          (ip_ftw),
        .ip_ftw_load     (ip_ftw_load),
        .ip_phase_offset (ip_phase_offset),
        .ip_burst_len    (ip_burst_len),
        .nco             (nif.master),
        .op_busy         (op_busy),
        .op_done         (op_done),
        .op_sample_count (op_sample_count)
    );

    always #5 ip_clock = ~ip_clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge ip_clock);
        #1;
    endtask

    // Reference: the k-th issued phase of a burst with a constant tuning word.
    function automatic int ref_phase(input int k, input int ftw, input int off);
        int acc;
        acc = (k * ftw) % (1 << ACC_W);
`ifdef NCO_PHASE_ROUND_EN
        acc = (acc + (1 << (ACC_W - 4))) % (1 << ACC_W);
`endif
        return ((acc >> (ACC_W - 3)) + off) % 8;
    endfunction

    task automatic start_burst(input int ftw, input int off, input int len, input bit with_stop);
        ip_ftw = ACC_W'(ftw);
        ip_ftw_load = 1'b1;
        tick();
        ip_ftw_load = 1'b0;
        ip_phase_offset = 3'(off);
        ip_burst_len = CNT_W'(len);
        ip_start = 1'b1;
        ip_stop = with_stop;
        tick();
        ip_start = 1'b0;
        ip_stop = 1'b0;
        obs.delete();
    endtask

    task automatic run_burst(input int max_ticks, input bit rand_ready);
        bit saw_done;
        saw_done = 1'b0;
        for (int i = 0; i < max_ticks && !saw_done; i++) begin
            nif.ip_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            if (nif.op_phase_valid) obs.push_back(int'(nif.op_phase));
            if (op_done) begin
                saw_done = 1'b1;
                check("done_with_last_sample_valid", nif.op_sample_valid, 1);
                check("not_busy_at_done", op_busy, 0);
            end
        end
        nif.ip_ready = 1'b1;
        check("burst_finished_in_budget", saw_done, 1);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            check($sformatf("%s_phase%0d", tag, i), obs[i], exp_q[i]);
    endtask

    initial begin
        nif.ip_ready = 1'b1;

        // reset state
        tick();
        tick();
        check("rst_phase", nif.op_phase, 0);
        check("rst_pvalid", nif.op_phase_valid, 0);
        check("rst_svalid", nif.op_sample_valid, 0);
        check("rst_busy", op_busy, 0);
        check("rst_done", op_done, 0);
        check("rst_count", op_sample_count, 0);
        ip_reset = 1'b1;
        tick();

        // 8-sample burst, cycle-exact timing
        start_burst(16'h2000, 0, 8, 1'b0);
        check("t2_busy_after_start", op_busy, 1);
        for (int t = 1; t <= 10; t++) begin
            tick();
            check($sformatf("t2_pvalid_c%0d", t), nif.op_phase_valid, (t <= 8));
            check($sformatf("t2_svalid_c%0d", t), nif.op_sample_valid, (t >= 2 && t <= 9));
            check($sformatf("t2_done_c%0d", t), op_done, (t == 9));
            check($sformatf("t2_busy_c%0d", t), op_busy, (t <= 8));
            if (t <= 8) check($sformatf("t2_phase_c%0d", t), nif.op_phase, t - 1);
        end
        check("t2_count", op_sample_count, 8);

        // stall after 3rd sample; a start during the stall is ignored
        start_burst(16'h2000, 0, 8, 1'b0);
        for (int t = 0; t < 3; t++) begin
            tick();
            if (nif.op_phase_valid) obs.push_back(int'(nif.op_phase));
        end
        nif.ip_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            ip_start = (t == 1);
            tick();
            check("t3_stall_pvalid", nif.op_phase_valid, 0);
            check("t3_stall_phase", nif.op_phase, 2);
            check("t3_stall_busy", op_busy, 1);
        end
        ip_start = 1'b0;
        run_burst(30, 1'b0);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_seq("t3");
        check("t3_count", op_sample_count, 8);

        // continuous mode, retune only at wrap, then stop
        start_burst(16'h2000, 0, 0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            tick();
            if (nif.op_phase_valid) obs.push_back(int'(nif.op_phase));
        end
        ip_ftw = 16'h4000;
        ip_ftw_load = 1'b1;
        tick();
        if (nif.op_phase_valid) obs.push_back(int'(nif.op_phase));
        ip_ftw_load = 1'b0;
        for (int t = 0; t < 9; t++) begin
            tick();
            if (nif.op_phase_valid) obs.push_back(int'(nif.op_phase));
        end
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 2, 4, 6, 0};
        check_seq("t4");
        ip_stop = 1'b1;
        tick();
        ip_stop = 1'b0;
        check("t5_stop_pvalid", nif.op_phase_valid, 0);
        check("t5_stop_svalid", nif.op_sample_valid, 1);
        check("t5_stop_busy", op_busy, 1);
        check("t5_stop_done", op_done, 0);
        tick();
        check("t5_flush_done", op_done, 1);
        check("t5_flush_busy", op_busy, 0);
        check("t5_flush_svalid", nif.op_sample_valid, 0);
        check("t5_count", op_sample_count, 13);
        tick();
        check("t5_done_one_cycle", op_done, 0);
        check("t5_count_held", op_sample_count, 13);

        // offset and rounding; start with stop in the same cycle still starts
        start_burst(16'h1000, 3, 6, 1'b1);
        check("t6_start_wins_busy", op_busy, 1);
        run_burst(20, 1'b0);
`ifdef NCO_PHASE_ROUND_EN
        exp_q = '{3, 4, 4, 5, 5, 6};
`else
        exp_q = '{3, 3, 4, 4, 5, 5};
`endif
        check_seq("t6");

        // async reset mid-burst between edges
        start_burst(16'h2000, 0, 8, 1'b0);
        tick();
        tick();
        #2;
        ip_reset = 1'b0;
        #1;
        check("t1_phase", nif.op_phase, 0);
        check("t1_pvalid", nif.op_phase_valid, 0);
        check("t1_svalid", nif.op_sample_valid, 0);
        check("t1_busy", op_busy, 0);
        check("t1_done", op_done, 0);
        check("t1_count", op_sample_count, 0);
        tick();
        check("t1_done_in_reset", op_done, 0);
        ip_reset = 1'b1;
        tick();
        check("t1_idle_after_release", op_busy, 0);
        check("t1_no_done_after_release", op_done, 0);
        check("t1_no_valid_after_release", nif.op_phase_valid, 0);

        // randomized bursts with random back-pressure
        for (int r = 0; r < 8; r++) begin
            int ftw, off, len;
            ftw = int'($urandom_range(1, 65535));
            off = int'($urandom_range(0, 7));
            len = int'($urandom_range(1, 20));
            start_burst(ftw, off, len, 1'b0);
            run_burst(200, 1'b1);
            exp_q.delete();
            for (int k = 0; k < len; k++) exp_q.push_back(ref_phase(k, ftw, off));
            check_seq($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_count", r), op_sample_count, len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
